// File: rtl/seg7_pkg.sv
// Shared types and the active-high segment lookup table for the 7-segment scan driver.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Segment order is {g,f,e,d,c,b,a}; codes 10-15 are not decimal digits and stay dark.
  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to 7-segment glyph lookup, active-high; the top level applies board polarity.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  assign seg = SEG_LUT[bcd];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with dead-cycle anti-ghosting and frame-synchronous updates.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, digit 0 always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW    = $clog2(TICKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // XOR masks: all-ones for active-low boards, so "off" and polarity share one constant.
  localparam seg_t                  SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         display_q, display_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  bcd_t cur_digit;
  logic cur_blank;
  seg_t dec_seg;
  logic tick_end;
  logic boundary;

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Select the digit under scan and decide whether it is suppressed as a leading zero.
  always_comb begin
    cur_digit = 4'h0;
    cur_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        zero_run  = zero_run & (display_q[4*k +: 4] == 4'h0);
        cur_blank = (idx_q == IDX_W'(k)) ? (zero_run && (k != 0)) : cur_blank;
      end
    end
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_digit = (idx_q == IDX_W'(k)) ? display_q[4*k +: 4] : cur_digit;
    end
  end

  // Scan counters, pending/display handoff and next output values.
  always_comb begin
    tick_end        = (presc_q == PRESC_LAST);
    boundary        = en && tick_end && (idx_q == IDX_LAST);
    presc_d         = presc_q;
    idx_d           = idx_q;
    seg_d           = seg_q;
    an_d            = an_q;
    frame_done_d    = boundary;
    pending_d       = load ? bcd_in : pending_q;
    display_d       = (boundary && pending_valid_q) ? pending_q : display_q;

    if (load) begin
      pending_valid_d = 1'b1;
    end else if (boundary) begin
      pending_valid_d = 1'b0;
    end else begin
      pending_valid_d = pending_valid_q;
    end

    if (en) begin
      if (tick_end) begin
        presc_d = PW'(0);
        idx_d   = (idx_q == IDX_LAST) ? IDX_W'(0) : idx_q + IDX_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
      end
      // Slot start is the dead cycle: everything dark so the previous digit cannot ghost.
      if (presc_q == PW'(0)) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end else begin
        seg_d = (cur_blank ? SEG_BLANK : dec_seg) ^ SEG_OFF;
        an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
      end
    end else begin
      presc_d = presc_q;
      idx_d   = idx_q;
      seg_d   = seg_q;
      an_d    = an_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q         <= PW'(0);
      idx_q           <= IDX_W'(0);
      display_q       <= {DW{1'b0}};
      pending_q       <= {DW{1'b0}};
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_OFF;
      an_q            <= AN_OFF;
      frame_done_q    <= 1'b0;
    end else begin
      presc_q         <= presc_d;
      idx_q           <= idx_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (2 digits, 4 ticks per digit, active-low outputs).
// Leading-zero expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] bcd_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  seg7_scan_driver #(
    .NUM_DIGITS      (2),
    .TICKS_PER_DIGIT (4),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp_seg, input logic [1:0] exp_an);
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, exp_seg});
    chk({tag, ".an"}, {6'b0, an}, {6'b0, exp_an});
  endtask

  task automatic chk_fd(input string tag, input logic exp_fd);
    chk({tag, ".frame_done"}, {7'b0, frame_done}, {7'b0, exp_fd});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 8'h00;
    adv(2);
    chk_out("reset", 7'h7F, 2'b11);
    chk_fd("reset", 1'b0);
    rst = 1'b0; en = 1'b1; load = 1'b1; bcd_in = 8'h42;

    // first frame: display still zero, dead cycle then digit 0
    adv(1); load = 1'b0; bcd_in = 8'h00;
    chk_out("dead0", 7'h7F, 2'b11);
    adv(1); chk_out("slot0", 7'h40, 2'b10); chk_fd("slot0", 1'b0);
    adv(6); chk_fd("frame1", 1'b1);
    adv(1); chk_fd("after_frame1", 1'b0); chk_out("dead1", 7'h7F, 2'b11);
    adv(1); chk_out("show42_d0", 7'h24, 2'b10);
    adv(4); chk_out("show42_d1", 7'h19, 2'b01);
    adv(2); chk_fd("frame2_period8", 1'b1);

    // mid-frame reload: current frame keeps 42
    adv(1); load = 1'b1; bcd_in = 8'h42;
    adv(1); load = 1'b1; bcd_in = 8'h97;
    adv(1); load = 1'b0; bcd_in = 8'h55;
    adv(4); chk_out("tearfree_d1", 7'h19, 2'b01);
    adv(1); chk_fd("frame3", 1'b1);
    adv(2); chk_out("show97_d0", 7'h78, 2'b10);
    adv(4); chk_out("show97_d1", 7'h10, 2'b01);

    // load coincident with the frame boundary
    load = 1'b1; bcd_in = 8'h13;
    adv(1); load = 1'b1; bcd_in = 8'h68;
    adv(1); chk_fd("frame4", 1'b1); load = 1'b0; bcd_in = 8'h00;
    adv(2); chk_out("show13_d0", 7'h30, 2'b10);
    adv(4); chk_out("show13_d1", 7'h79, 2'b01);
    adv(2); chk_fd("frame5", 1'b1);
    adv(2); chk_out("show68_d0", 7'h00, 2'b10);
    adv(4); chk_out("show68_d1", 7'h02, 2'b01);

    // freeze just before a frame boundary
    adv(1); chk_out("prefreeze", 7'h02, 2'b01);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk_out("frozen", 7'h02, 2'b01);
      chk_fd("frozen", 1'b0);
    end
    en = 1'b1;
    adv(1); chk_fd("resume_boundary", 1'b1); chk_out("resume", 7'h02, 2'b01);

    // 0B: digit 0 is a non-decimal code, digit 1 a leading zero
    load = 1'b1; bcd_in = 8'h0B;
    adv(1); load = 1'b0;
    adv(7); chk_fd("frame_0b", 1'b1);
    adv(2); chk_out("show0b_d0", 7'h7F, 2'b10);
    adv(4); chk_out("show0b_d1", LZ_SEG, 2'b01);
    load = 1'b1; bcd_in = 8'h05;
    adv(1); load = 1'b0;
    adv(1); chk_fd("frame_05", 1'b1);
    adv(2); chk_out("show05_d0", 7'h12, 2'b10);
    adv(4); chk_out("show05_d1", LZ_SEG, 2'b01);
    load = 1'b1; bcd_in = 8'h00;
    adv(1); load = 1'b0;
    adv(1); chk_fd("frame_00", 1'b1);
    adv(2); chk_out("show00_d0", 7'h40, 2'b10);

    // reset mid-frame with a pending load outstanding
    load = 1'b1; bcd_in = 8'h88;
    adv(1); load = 1'b0; rst = 1'b1;
    adv(1); chk_out("midreset", 7'h7F, 2'b11); chk_fd("midreset", 1'b0);
    rst = 1'b0;
    adv(1); chk_out("postrst_dead", 7'h7F, 2'b11);
    adv(1); chk_out("postrst_slot0", 7'h40, 2'b10);
    adv(6); chk_fd("postrst_frame", 1'b1);
    adv(2); chk_out("pending_discarded_d0", 7'h40, 2'b10);
    adv(4); chk_out("pending_discarded_d1", LZ_SEG, 2'b01);
    adv(2); chk_fd("postrst_frame2", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
